// File: rtl/uart_pkg.sv
// Shared encodings and constants for the BCD UART receive path.
// Byte-receiver and message-parser state types live here so debug tooling sees one definition.
package uart_pkg;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    typedef enum logic [1:0] {
        EXP_D1   = 2'd0,
        EXP_D0   = 2'd1,
        EXP_TERM = 2'd2
    } parse_state_t;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_NINE = 8'h39;
    localparam logic [7:0] ASCII_CR   = 8'h0D;

    localparam int CLK_DIV_DEFAULT = 5208;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= ASCII_ZERO) && (b <= ASCII_NINE);
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-flop synchroniser, mid-bit sampling via a down-counting baud timer.
// state | meaning: IDLE wait for falling edge | START verify start bit | DATA shift 8 bits | STOP check stop bit
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    output logic [7:0] rx_data,
    output logic       rx_strobe,
    output logic       frame_err,
    output logic [1:0] state
);

    localparam logic [15:0] HALF_LOAD = 16'(CLK_DIV / 2 - 1);
    localparam logic [15:0] FULL_LOAD = 16'(CLK_DIV - 1);

    logic        r_sync1;
    logic        r_sync2;
    logic        r_sync_d;
    logic [15:0] r_cnt;
    logic [2:0]  r_idx;
    logic [7:0]  r_shift;
    logic [7:0]  r_data;
    logic        r_strobe;
    logic        r_ferr;
    rx_state_t   r_state;
    rx_state_t   w_state_nxt;
    logic        w_fall;
    logic        w_expire;

    assign w_fall   = r_sync_d & ~r_sync2;
    assign w_expire = (r_cnt == 16'd0);

    // Sync flops reset high so a line already idle at reset release is not seen as a start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_sync_d <= 1'b1;
        end else begin
            r_sync1  <= rx_in;
            r_sync2  <= r_sync1;
            r_sync_d <= r_sync2;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= RX_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RX_IDLE:  if (w_fall) w_state_nxt = RX_START;
            RX_START: if (w_expire) w_state_nxt = r_sync2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_expire && (r_idx == 3'd7)) w_state_nxt = RX_STOP;
            RX_STOP:  if (w_expire) w_state_nxt = RX_IDLE;
            default:  w_state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt    <= 16'd0;
            r_idx    <= 3'd0;
            r_shift  <= 8'd0;
            r_data   <= 8'd0;
            r_strobe <= 1'b0;
            r_ferr   <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            r_ferr   <= 1'b0;
            case (r_state)
                RX_IDLE: begin
                    if (w_fall) r_cnt <= HALF_LOAD;
                end
                RX_START: begin
                    if (!w_expire) begin
                        r_cnt <= r_cnt - 16'd1;
                    end else if (!r_sync2) begin
                        r_cnt <= FULL_LOAD;
                        r_idx <= 3'd0;
                    end
                end
                RX_DATA: begin
                    if (!w_expire) begin
                        r_cnt <= r_cnt - 16'd1;
                    end else begin
                        r_shift[r_idx] <= r_sync2;
                        r_cnt          <= FULL_LOAD;
                        r_idx          <= r_idx + 3'd1;
                    end
                end
                RX_STOP: begin
                    if (!w_expire) begin
                        r_cnt <= r_cnt - 16'd1;
                    end else if (r_sync2) begin
                        r_data   <= r_shift;
                        r_strobe <= 1'b1;
                    end else begin
                        r_ferr <= 1'b1;
                    end
                end
                default: r_cnt <= 16'd0;
            endcase
        end
    end

    assign rx_data   = r_data;
    assign rx_strobe = r_strobe;
    assign frame_err = r_ferr;
    assign state     = r_state;

endmodule

// File: rtl/uart_bcd_rx.sv
// BCD message receiver: parses "<tens><units><TERM>" from the byte stream into held BCD digits.
// state | meaning: EXP_D1 expect tens digit | EXP_D0 expect units digit | EXP_TERM expect terminator
module uart_bcd_rx
    import uart_pkg::*;
#(
    parameter int         CLK_DIV   = CLK_DIV_DEFAULT,
    parameter logic [7:0] TERM_CHAR = ASCII_CR
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    output logic [6:0] bcd0,
    output logic [6:0] bcd1,
    output logic       msg_valid,
    output logic [7:0] rx_data,
    output logic       rx_strobe,
    output logic       frame_err,
    output logic       fmt_err,
    output logic [1:0] state_out
);

    logic [7:0]   w_rx_data;
    logic         w_rx_strobe;
    logic         w_frame_err;
    logic [1:0]   w_state;
    logic [3:0]   w_digit;
    logic         w_is_digit;
    logic         w_take_tens;
    logic         w_take_units;
    logic         w_commit;
    logic         w_fmt;
    parse_state_t r_pst;
    parse_state_t w_pst_nxt;
    logic [3:0]   r_tens;
    logic [3:0]   r_units;
    logic [3:0]   r_bcd1;
    logic [3:0]   r_bcd0;
    logic         r_msg_valid;
    logic         r_fmt_err;

    uart_rx_byte #(.CLK_DIV(CLK_DIV)) u_rx_byte (
        .clk       (clk),
        .rst       (rst),
        .rx_in     (rx_in),
        .rx_data   (w_rx_data),
        .rx_strobe (w_rx_strobe),
        .frame_err (w_frame_err),
        .state     (w_state)
    );

    assign w_is_digit = is_digit(w_rx_data);
    assign w_digit    = 4'(w_rx_data - ASCII_ZERO);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_pst <= EXP_D1;
        else      r_pst <= w_pst_nxt;
    end

    always_comb begin
        w_pst_nxt    = r_pst;
        w_take_tens  = 1'b0;
        w_take_units = 1'b0;
        w_commit     = 1'b0;
        w_fmt        = 1'b0;
        if (w_frame_err) begin
            w_pst_nxt = EXP_D1;
        end else if (w_rx_strobe) begin
            case (r_pst)
                EXP_D1: begin
                    if (w_is_digit) begin
                        w_take_tens = 1'b1;
                        w_pst_nxt   = EXP_D0;
                    end else begin
                        w_fmt = 1'b1;
                    end
                end
                EXP_D0: begin
                    if (w_is_digit) begin
                        w_take_units = 1'b1;
                        w_pst_nxt    = EXP_TERM;
                    end else begin
                        w_fmt     = 1'b1;
                        w_pst_nxt = EXP_D1;
                    end
                end
                EXP_TERM: begin
                    if (w_rx_data == TERM_CHAR) w_commit = 1'b1;
                    else                        w_fmt    = 1'b1;
                    w_pst_nxt = EXP_D1;
                end
                default: w_pst_nxt = EXP_D1;
            endcase
        end
    end

    // Partial digits are dropped on a framing error; the held display value is untouched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tens      <= 4'd0;
            r_units     <= 4'd0;
            r_bcd1      <= 4'd0;
            r_bcd0      <= 4'd0;
            r_msg_valid <= 1'b0;
            r_fmt_err   <= 1'b0;
        end else begin
            r_msg_valid <= w_commit;
            r_fmt_err   <= w_fmt;
            if (w_frame_err) begin
                r_tens  <= 4'd0;
                r_units <= 4'd0;
            end else begin
                if (w_take_tens)  r_tens  <= w_digit;
                if (w_take_units) r_units <= w_digit;
            end
            if (w_commit) begin
                r_bcd1 <= r_tens;
                r_bcd0 <= r_units;
            end
        end
    end

    assign bcd1      = {3'b000, r_bcd1};
    assign bcd0      = {3'b000, r_bcd0};
    assign msg_valid = r_msg_valid;
    assign fmt_err   = r_fmt_err;
    assign rx_data   = w_rx_data;
    assign rx_strobe = w_rx_strobe;
    assign frame_err = w_frame_err;
    assign state_out = w_state;

endmodule

// File: tb/tb_uart_bcd_rx.sv
// Bench for uart_bcd_rx: directed message sequences then random frames, checked against
// a message-level reference model of the byte and parser rules.
module tb_uart_bcd_rx;

    localparam int DIV = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx_in = 1'b1;
    logic [6:0] bcd0;
    logic [6:0] bcd1;
    logic       msg_valid;
    logic [7:0] rx_data;
    logic       rx_strobe;
    logic       frame_err;
    logic       fmt_err;
    logic [1:0] state_out;

    uart_bcd_rx #(.CLK_DIV(DIV), .TERM_CHAR(8'h0D)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_in     (rx_in),
        .bcd0      (bcd0),
        .bcd1      (bcd1),
        .msg_valid (msg_valid),
        .rx_data   (rx_data),
        .rx_strobe (rx_strobe),
        .frame_err (frame_err),
        .fmt_err   (fmt_err),
        .state_out (state_out)
    );

    always #10 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Pulse observation
    int   got_strobe = 0;
    int   got_ferr   = 0;
    int   got_fmt    = 0;
    int   got_msg    = 0;
    logic prev_strobe = 1'b0;

    always @(negedge clk) begin
        if (rx_strobe) got_strobe++;
        if (frame_err) got_ferr++;
        if (fmt_err)   got_fmt++;
        if (msg_valid) begin
            got_msg++;
            chk_eq("msg_latency", 32'(prev_strobe), 32'd1);
            chk_eq("msg_fmt_excl", 32'(fmt_err), 32'd0);
        end
        if (rx_strobe) chk_eq("strobe_ferr_excl", 32'(frame_err), 32'd0);
        prev_strobe = rx_strobe;
    end

    // Reference model: message position plus held digits
    int         exp_strobe = 0;
    int         exp_ferr   = 0;
    int         exp_fmt    = 0;
    int         exp_msg    = 0;
    logic [7:0] m_data     = 8'd0;
    int         m_bcd1     = 0;
    int         m_bcd0     = 0;
    int         m_pos      = 0;
    int         m_tens     = 0;
    int         m_units    = 0;

    function automatic bit digit_char(input logic [7:0] b);
        return (b >= 8'd48) && (b <= 8'd57);
    endfunction

    task automatic model_frame(input logic [7:0] b, input bit stop_ok);
        if (!stop_ok) begin
            exp_ferr++;
            m_pos = 0;
        end else begin
            exp_strobe++;
            m_data = b;
            if (m_pos == 0) begin
                if (digit_char(b)) begin m_tens = int'(b) - 48; m_pos = 1; end
                else exp_fmt++;
            end else if (m_pos == 1) begin
                if (digit_char(b)) begin m_units = int'(b) - 48; m_pos = 2; end
                else begin exp_fmt++; m_pos = 0; end
            end else begin
                if (b == 8'h0D) begin m_bcd1 = m_tens; m_bcd0 = m_units; exp_msg++; end
                else exp_fmt++;
                m_pos = 0;
            end
        end
    endtask

    task automatic model_reset();
        m_data = 8'd0;
        m_bcd1 = 0;
        m_bcd0 = 0;
        m_pos  = 0;
    endtask

    task automatic check_all();
        chk_eq("strobe_count", got_strobe, exp_strobe);
        chk_eq("frame_err_count", got_ferr, exp_ferr);
        chk_eq("fmt_err_count", got_fmt, exp_fmt);
        chk_eq("msg_count", got_msg, exp_msg);
        chk_eq("rx_data", 32'(rx_data), 32'(m_data));
        chk_eq("bcd1", 32'(bcd1), m_bcd1);
        chk_eq("bcd0", 32'(bcd0), m_bcd0);
        chk_eq("state_idle", 32'(state_out), 32'd0);
        chk_eq("pulses_quiet", {28'd0, rx_strobe, frame_err, fmt_err, msg_valid}, 32'd0);
    endtask

    task automatic drive_bit(input logic v);
        @(negedge clk);
        rx_in = v;
        repeat (DIV - 1) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_ok);
        @(negedge clk);
        rx_in = 1'b1;
        repeat (3 * DIV) @(negedge clk);
        model_frame(b, stop_ok);
        check_all();
    endtask

    task automatic send_msg(input logic [7:0] d1, input logic [7:0] d0);
        send_frame(d1, 1'b1);
        send_frame(d0, 1'b1);
        send_frame(8'h0D, 1'b1);
    endtask

    task automatic glitch(input int len);
        @(negedge clk);
        rx_in = 1'b0;
        repeat (len) @(negedge clk);
        rx_in = 1'b1;
        repeat (3 * DIV) @(negedge clk);
        check_all();
    endtask

    initial begin
        logic [7:0] b;
        int         kind;
        bit         ok;

        rx_in = 1'b1;
        rst   = 1'b0;
        repeat (3) @(negedge clk);
        check_all();
        rst = 1'b1;
        repeat (5) @(negedge clk);

        send_msg("1", "2");
        send_msg("0", "9");
        send_msg("1", "2");
        send_msg("0", "9");

        glitch(5);

        send_frame("3", 1'b0);
        send_msg("4", "5");

        send_msg("1", "A");

        // Reset mid-DATA of '7'
        b = "7";
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(b[i]);
        chk_eq("state_data", 32'(state_out), 32'd2);
        rst   = 1'b0;
        rx_in = 1'b1;
        model_reset();
        @(negedge clk);
        check_all();
        repeat (2) @(negedge clk);
        check_all();
        rst = 1'b1;
        repeat (3 * DIV) @(negedge clk);
        check_all();
        send_msg("8", "8");

        for (int n = 0; n < 40; n++) begin
            kind = int'($urandom_range(0, 9));
            ok   = ($urandom_range(0, 9) != 0);
            if (kind <= 5)      b = 8'(8'd48 + 8'($urandom_range(0, 9)));
            else if (kind <= 7) b = 8'h0D;
            else                b = 8'($urandom_range(0, 255));
            if (kind == 9) glitch(int'($urandom_range(1, 6)));
            else           send_frame(b, ok);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
